// File: rtl/kyber_pkg.sv
// Kyber-768 shared constants, twiddles and modular helpers.
// Zetas are canonical 17^bitrev7(k) mod q, no Montgomery factor.
package kyber_pkg;

  localparam int KYBER_Q  = 3329;
  localparam int KYBER_N  = 256;
  localparam int NTT_NINV = 3303;

  typedef logic [127:0][11:0] zeta_tbl_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BFLY  = 2'd1,
    SCALE = 2'd2
  } intt_state_t;

  function automatic zeta_tbl_t gen_zetas();
    zeta_tbl_t  t;
    int         p;
    logic [6:0] k7;
    logic [6:0] r;
    t = '0;
    r = '0;
    for (int k = 0; k < 128; k++) begin
      k7 = 7'(k);
      for (int b = 0; b < 7; b++) begin
        r[b] = k7[6-b];
      end
      p = 1;
      for (int e = 0; e < int'(r); e++) begin
        p = (p * 17) % KYBER_Q;
      end
      t[k] = 12'(p);
    end
    return t;
  endfunction

  localparam zeta_tbl_t ZETAS = gen_zetas();

  function automatic logic [11:0] mulq(
    input logic [11:0] x,
    input logic [11:0] y
  );
    logic [23:0] p;
    p = {12'd0, x} * {12'd0, y};
    return 12'(p % 24'(KYBER_Q));
  endfunction

  function automatic logic [11:0] redq16(
    input logic [15:0] x
  );
    return 12'(x % 16'(KYBER_Q));
  endfunction

endpackage

// File: rtl/intt_if.sv
// Coefficient bus between the INTT core and its user.
// master drives enable/in, slave returns out/valid/busy.
interface intt_if;

  logic        enable;
  logic [15:0] in  [256];
  logic [15:0] out [256];
  logic        valid;
  logic        busy;

  modport master (
    output enable,
    output in,
    input  out,
    input  valid,
    input  busy
  );

  modport slave (
    input  enable,
    input  in,
    output out,
    output valid,
    output busy
  );

endinterface

// File: rtl/gentleman_sande.sv
// Gentleman-Sande butterfly on canonical operands mod q.
// out0 = a+b, out1 = zeta*(b-a); all unsigned.
module gentleman_sande
  import kyber_pkg::*;
(
  input  logic [11:0] a,
  input  logic [11:0] b,
  input  logic [11:0] zeta,
  output logic [11:0] out0,
  output logic [11:0] out1
);

  logic [12:0] sum;
  logic [12:0] dif;
  logic [11:0] dr;

  // modular sum, biased difference, then twiddle product
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    dif  = {1'b0, b} + 13'(KYBER_Q) - {1'b0, a};
    out0 = (sum >= 13'(KYBER_Q)) ?
           12'(sum - 13'(KYBER_Q)) : sum[11:0];
    dr   = (dif >= 13'(KYBER_Q)) ?
           12'(dif - 13'(KYBER_Q)) : dif[11:0];
    out1 = mulq(zeta, dr);
  end

endmodule

// File: rtl/intt.sv
// Kyber inverse NTT: 7 GS stages, one per clock,
// then optional scale by 128^-1 mod q.
module intt
  import kyber_pkg::*;
#(
  parameter bit SCALE_EN = 1'b1
) (
  input logic   clk,
  input logic   rst_n,
  intt_if.slave bus
);

  localparam int NB = KYBER_N / 2;

  intt_state_t state;
  intt_state_t state_nxt;

  logic [2:0]  stage;
  logic        cap;
  logic        step;
  logic        wr_bf;
  logic        wr_sc;

  logic [11:0] coef [KYBER_N];
  logic [11:0] nxt  [KYBER_N];

  logic [11:0] a_s  [8][NB];
  logic [11:0] b_s  [8][NB];
  logic [11:0] z_s  [8][NB];
  logic [11:0] wb_s [8][KYBER_N];

  logic [11:0] a  [NB];
  logic [11:0] b  [NB];
  logic [11:0] z  [NB];
  logic [11:0] o0 [NB];
  logic [11:0] o1 [NB];

  for (genvar s = 0; s < 8; s++) begin : g_stage
    for (genvar i = 0; i < NB; i++) begin : g_op
      if (s < 7) begin : g_on
        localparam int LEN = 2 << s;
        localparam int J   = (i / LEN) * 2 * LEN
                           + (i % LEN);
        localparam int ZI  = (128 >> s) - 1
                           - (i >> (s + 1));
        assign a_s[s][i] = coef[J];
        assign b_s[s][i] = coef[J + LEN];
        assign z_s[s][i] = ZETAS[ZI];
      end else begin : g_off
        assign a_s[s][i] = '0;
        assign b_s[s][i] = '0;
        assign z_s[s][i] = '0;
      end
    end
    for (genvar k = 0; k < KYBER_N; k++) begin : g_wb
      if (s < 7) begin : g_on
        localparam int LEN = 2 << s;
        localparam int I   = (k / (2 * LEN)) * LEN
                           + (k % LEN);
        localparam bit HI  = ((k / LEN) % 2) == 1;
        if (HI) begin : g_hi
          assign wb_s[s][k] = o1[I];
        end else begin : g_lo
          assign wb_s[s][k] = o0[I];
        end
      end else begin : g_off
        assign wb_s[s][k] = '0;
      end
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_gs
    gentleman_sande u_gs (
      .a    (a[i]),
      .b    (b[i]),
      .zeta (z[i]),
      .out0 (o0[i]),
      .out1 (o1[i])
    );
  end

  // route the current stage's operands and results
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      a[i] = a_s[stage][i];
      b[i] = b_s[stage][i];
      z[i] = z_s[stage][i];
    end
    for (int k = 0; k < KYBER_N; k++) begin
      nxt[k] = wb_s[stage][k];
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next state and datapath strobes
  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    step      = 1'b0;
    wr_bf     = 1'b0;
    wr_sc     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.enable) begin
          cap       = 1'b1;
          state_nxt = BFLY;
        end
      end
      BFLY: begin
        step = 1'b1;
        if (stage == 3'd6) begin
          if (SCALE_EN) begin
            state_nxt = SCALE;
          end else begin
            wr_bf     = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      SCALE: begin
        wr_sc     = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // stage counter, busy and result pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage     <= '0;
      bus.busy  <= 1'b0;
      bus.valid <= 1'b0;
    end else begin
      bus.valid <= wr_bf | wr_sc;
      if (cap) begin
        stage    <= '0;
        bus.busy <= 1'b1;
      end
      if (step) begin
        stage <= (stage == 3'd6) ? '0 : stage + 3'd1;
      end
      if (wr_bf | wr_sc) begin
        bus.busy <= 1'b0;
      end
    end
  end

  // working coefficients: capture with reduction, then stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < KYBER_N; k++) begin
        coef[k] <= '0;
      end
    end else if (cap) begin
      for (int k = 0; k < KYBER_N; k++) begin
        coef[k] <= redq16(bus.in[k]);
      end
    end else if (step) begin
      for (int k = 0; k < KYBER_N; k++) begin
        coef[k] <= nxt[k];
      end
    end
  end

  // output register, held until the next result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < KYBER_N; k++) begin
        bus.out[k] <= '0;
      end
    end else if (wr_bf) begin
      for (int k = 0; k < KYBER_N; k++) begin
        bus.out[k] <= {4'd0, nxt[k]};
      end
    end else if (wr_sc) begin
      for (int k = 0; k < KYBER_N; k++) begin
        bus.out[k] <= {4'd0,
          mulq(coef[k], 12'(NTT_NINV))};
      end
    end
  end

endmodule

// File: tb/tb_intt.sv
// Bench for intt: textbook loop model, golden forward NTT,
// directed vectors, back-to-back and abort scenarios.
module tb_intt;

  localparam int Q = 3329;

  typedef int poly_t [256];

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  intt_if bus0 ();
  intt_if bus1 ();

  intt #(.SCALE_EN(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  intt #(.SCALE_EN(1'b0)) u_ns (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    zt [128];
  poly_t expq [2][64];
  int    wr [2];
  int    rd [2];
  int    vcyc [2][64];
  int    vcnt [2];
  bit    pv [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int powq(input int bs, input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * bs) % Q;
    return r;
  endfunction

  function automatic int brv7(input int x);
    int r;
    r = 0;
    for (int i = 0; i < 7; i++)
      if (x[i]) r = r | (1 << (6 - i));
    return r;
  endfunction

  function automatic void fwd_ntt(input poly_t x, output poly_t y);
    int k, t, z;
    y = x;
    k = 1;
    for (int len = 128; len >= 2; len = len >> 1)
      for (int st = 0; st < 256; st += 2 * len) begin
        z = zt[k];
        k++;
        for (int j = st; j < st + len; j++) begin
          t = (z * y[j + len]) % Q;
          y[j + len] = (y[j] - t + Q) % Q;
          y[j] = (y[j] + t) % Q;
        end
      end
  endfunction

  function automatic void model_intt(input poly_t x, input bit scale,
                                     output poly_t y);
    int k, t, z;
    for (int i = 0; i < 256; i++) y[i] = x[i] % Q;
    k = 127;
    for (int len = 2; len <= 128; len = len << 1)
      for (int st = 0; st < 256; st += 2 * len) begin
        z = zt[k];
        k--;
        for (int j = st; j < st + len; j++) begin
          t = y[j];
          y[j] = (t + y[j + len]) % Q;
          y[j + len] = (z * ((y[j + len] - t + Q) % Q)) % Q;
        end
      end
    if (scale)
      for (int i = 0; i < 256; i++) y[i] = (y[i] * 3303) % Q;
  endfunction

  function automatic int ndiff(input poly_t p, input poly_t q2);
    int n;
    n = 0;
    for (int i = 0; i < 256; i++) if (p[i] != q2[i]) n++;
    return n;
  endfunction

  function automatic int nz_out(input int d);
    int n;
    n = 0;
    for (int i = 0; i < 256; i++)
      if ((d == 0 ? bus0.out[i] : bus1.out[i]) != 16'd0) n++;
    return n;
  endfunction

  function automatic int get_busy(input int d);
    return d == 0 ? int'(bus0.busy) : int'(bus1.busy);
  endfunction

  function automatic int get_valid(input int d);
    return d == 0 ? int'(bus0.valid) : int'(bus1.valid);
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  task automatic set_in(input int d, input poly_t x);
    for (int i = 0; i < 256; i++)
      if (d == 0) bus0.in[i] = 16'(x[i]);
      else bus1.in[i] = 16'(x[i]);
  endtask

  task automatic set_en(input int d, input bit e);
    if (d == 0) bus0.enable = e;
    else bus1.enable = e;
  endtask

  task automatic push(input int d, input poly_t e);
    expq[d][wr[d] % 64] = e;
    wr[d]++;
  endtask

  task automatic check_out(input int d, input poly_t got);
    poly_t e;
    int nb, bi;
    total++;
    vcyc[d][vcnt[d] % 64] = cyc;
    vcnt[d]++;
    if (rd[d] == wr[d]) begin
      bad++;
      $display("FAIL unexpected_valid dut%0d cyc=%0d", d, cyc);
    end else begin
      e = expq[d][rd[d] % 64];
      rd[d]++;
      nb = 0;
      bi = 0;
      for (int i = 0; i < 256; i++)
        if (got[i] != e[i]) begin
          if (nb == 0) bi = i;
          nb++;
        end
      if (nb != 0) begin
        bad++;
        $display("FAIL out dut%0d txn%0d idx%0d got=%0d want=%0d wrong=%0d",
                 d, rd[d] - 1, bi, got[bi], e[bi], nb);
      end
    end
  endtask

  always @(negedge clk) begin
    poly_t got;
    for (int d = 0; d < 2; d++) begin
      bit v;
      v = get_valid(d) != 0;
      if (v) begin
        for (int i = 0; i < 256; i++)
          got[i] = d == 0 ? int'(bus0.out[i]) : int'(bus1.out[i]);
        check_out(d, got);
        chk($sformatf("pulse_dut%0d", d), int'(pv[d]), 0);
      end
      pv[d] = v;
    end
  end

  task automatic wait_valid(input int d, input int want, input string nm);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      seen = get_valid(d) != 0;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s timeout got=none want=%0d", nm, want);
    end else begin
      chk(nm, n, want);
      chk({nm, "_busy"}, get_busy(d), 0);
    end
  endtask

  task automatic run_one(input int d, input poly_t x, input poly_t e,
                         input int lat, input string nm);
    @(negedge clk);
    set_in(d, x);
    push(d, e);
    set_en(d, 1'b1);
    @(posedge clk);
    #1;
    set_en(d, 1'b0);
    chk({nm, "_busy"}, get_busy(d), 1);
    wait_valid(d, lat, {nm, "_lat"});
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    poly_t ones, ones_r, c5, c5_r, r128, big, y, x, zero;
    poly_t orig [20];
    poly_t fin [20];
    int base, n;
    bit seen;

    for (int k = 0; k < 128; k++) zt[k] = powq(17, brv7(k));
    for (int k = 0; k < 256; k++) begin
      ones[k]   = 1;
      ones_r[k] = k < 2 ? 1 : 0;
      c5[k]     = k % 2 == 0 ? 5 : 0;
      c5_r[k]   = k == 0 ? 5 : 0;
      r128[k]   = k < 2 ? 128 : 0;
      big[k]    = 3330;
      zero[k]   = 0;
    end
    for (int d = 0; d < 2; d++) begin
      wr[d] = 0;
      rd[d] = 0;
      vcnt[d] = 0;
      pv[d] = 1'b0;
    end
    set_en(0, 1'b0);
    set_en(1, 1'b0);
    set_in(0, zero);
    set_in(1, zero);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(bus0.valid), 0);
    chk("rst_busy", int'(bus0.busy), 0);
    chk("rst_out", nz_out(0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    chk("model_zeta1", zt[1], 1729);
    model_intt(ones, 1'b1, y);
    chk("model_ones", ndiff(y, ones_r), 0);
    model_intt(c5, 1'b1, y);
    chk("model_c5", ndiff(y, c5_r), 0);
    model_intt(ones, 1'b0, y);
    chk("model_noscale", ndiff(y, r128), 0);
    model_intt(big, 1'b1, y);
    chk("model_3330", ndiff(y, ones_r), 0);

    run_one(0, ones, ones_r, 8, "ones");
    run_one(0, c5, c5_r, 8, "const5");
    run_one(0, big, ones_r, 8, "red3330");
    run_one(1, ones, r128, 7, "noscale");

    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_out0", nz_out(0), 0);
    chk("midrst_out1", nz_out(1), 0);
    chk("midrst_valid", int'(bus0.valid), 0);
    chk("midrst_busy", int'(bus0.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < 256; k++) orig[t][k] = int'($urandom_range(0, Q - 1));
      fwd_ntt(orig[t], fin[t]);
    end
    model_intt(fin[0], 1'b1, y);
    chk("model_roundtrip", ndiff(y, orig[0]), 0);

    base = vcnt[0];
    @(negedge clk);
    set_in(0, fin[0]);
    push(0, orig[0]);
    set_en(0, 1'b1);
    @(posedge clk);
    #1;
    for (int t = 1; t < 20; t++) begin
      set_in(0, fin[t]);
      push(0, orig[t]);
      repeat (9) @(posedge clk);
      #1;
    end
    set_en(0, 1'b0);
    wait_valid(0, 8, "b2b_last");
    repeat (3) @(posedge clk);
    chk("b2b_count", vcnt[0] - base, 20);
    for (int t = 1; t < 20; t++)
      chk($sformatf("b2b_gap%0d", t),
          vcyc[0][(base + t) % 64] - vcyc[0][(base + t - 1) % 64], 9);

    for (int it = 0; it < 2; it++) begin
      for (int k = 0; k < 256; k++) x[k] = int'($urandom_range(0, 65535));
      model_intt(x, 1'b1, y);
      @(negedge clk);
      set_in(0, x);
      push(0, y);
      set_en(0, 1'b1);
      @(posedge clk);
      #1;
      set_en(0, 1'b0);
      for (int k = 0; k < 256; k++) x[k] = int'($urandom_range(0, 65535));
      set_in(0, x);
      n = 0;
      seen = 1'b0;
      while (!seen && n < 20) begin
        @(posedge clk);
        #1;
        n++;
        seen = bus0.valid;
        if (!seen) set_en(0, n < 6 ? n[0] : 1'b0);
      end
      set_en(0, 1'b0);
      if (!seen) begin
        total++;
        bad++;
        $display("FAIL toggle_lat timeout got=none want=8");
      end else chk("toggle_lat", n, 8);
      repeat (3) @(posedge clk);
    end

    @(negedge clk);
    set_in(0, ones);
    push(0, ones_r);
    set_en(0, 1'b1);
    @(posedge clk);
    #1;
    set_en(0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    rd[0] = wr[0];
    #1;
    chk("abort_busy", int'(bus0.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (14) begin
      @(posedge clk);
      #1;
      if (bus0.valid) seen = 1'b1;
    end
    chk("abort_novalid", int'(seen), 0);
    chk("abort_out", nz_out(0), 0);
    run_one(0, ones, ones_r, 8, "after_abort");

    repeat (2) @(posedge clk);
    chk("drained0", wr[0] - rd[0], 0);
    chk("drained1", wr[1] - rd[1], 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intt.md
# intt

Inverse number-theoretic transform for Kyber-768 (q = 3329, n = 256). The block takes 256 coefficients in the NTT domain and returns the polynomial in normal coefficient order. It uses Gentleman–Sande butterflies with 128 butterflies per stage and one stage per clock. A final multiply by 128⁻¹ mod q follows the last stage. The block is the companion of the forward `ntt` and sits after the pointwise-multiply stage, before compress/encode.

## Interface
- `SCALE_EN`, default 1: 1 applies the final ×3303 (128⁻¹ mod q); 0 skips the scale step.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: start request, sampled only while idle.
- `in[0:255]`, input, 16 each: NTT-domain coefficients.
- `out[0:255]`, output, 16 each, registered: coefficients, canonical 0..3328.
- `valid`, output, 1: one-cycle pulse when `out` is updated.
- `busy`, output, 1: high from capture until the result is written.

## Operation
- FSM states: IDLE, BFLY, SCALE. A 3-bit `stage` counter runs 0..6.
- **IDLE**
  - If `enable`=1: `buf[k] <= in[k] mod q` for all k, `stage<=0`, `busy<=1`, go to BFLY.
  - Otherwise stay in IDLE.
- **BFLY**, stage s, len = 2<<s. For each butterfly i in 0..127:
  - j = (i/len)·2·len + (i mod len).
  - a = buf[j], b = buf[j+len].
  - zeta = ZETAS[(128>>s) − 1 − (i>>(s+1))].
  - Write back `buf[j] <= (a+b) mod q`.
  - Write back `buf[j+len] <= (zeta·((b − a + q) mod q)) mod q`.
  - If s=6: go to SCALE when `SCALE_EN`=1; otherwise write `out <= result`, `valid<=1`, `busy<=0`, go to IDLE.
  - Otherwise `stage<=stage+1`.
- **SCALE**: `out[k] <= (buf[k]·3303) mod q`, `valid<=1`, `busy<=0`, go to IDLE.
- Zeta indices used per stage:
  - s=0 uses indices 127..64.
  - s=6 uses index 1.
  - Index 0 is never used.
- `ZETAS[k]` = 17^bitrev7(k) mod q, stored canonical unsigned, with no Montgomery factor.
- Arithmetic widths:
  - Sums use 13 bits.
  - Products use a 12×12 → 24-bit unsigned multiply followed by an exact `mod q`.
  - No signed intermediate is used.
- `valid` is 0 in every cycle other than the write cycle. `out` holds its value until the next result or reset.
- `enable` during BFLY or SCALE is ignored. `in` is not re-sampled.
- Inputs ≥ q are reduced modulo q at capture. Values up to 65535 are legal.

## Timing
- Reset, asynchronous on `rst_n`=0, applies immediately:
  - state=IDLE, `stage`=0, `busy`=0, `valid`=0.
  - All `out` and `buf` = 0.
- Reset during BFLY or SCALE aborts the transform. No `valid` is produced.
- Capture edge E0 is the first rising edge with IDLE and `enable`=1.
- Stages 0..6 are applied on E1..E7.
- With `SCALE_EN`=1:
  - Scaling is applied on E8.
  - `valid`=1 in the cycle after E8, so latency is 8 edges.
- With `SCALE_EN`=0: `valid` is asserted after E7, so latency is 7 edges.
- Back-to-back operation: the state is IDLE during the `valid` cycle.
  - With `enable` held high, the next capture happens on the edge that ends the `valid` cycle.
  - Throughput is one transform per 9 cycles (8 with `SCALE_EN`=0).
- `busy` rises after E0 and falls together with the `valid` rise.

## Structure
- Package `kyber_pkg` holds:
  - `KYBER_Q`=3329, `KYBER_N`=256, `NTT_NINV`=3303.
  - `ZETAS[0:127]` as 12-bit unsigned, shared with forward `ntt` once that block is migrated to canonical zetas.
  - The `intt_state_t` enum.
- Sub-module `gentleman_sande`: a combinational butterfly with ports a, b (12-bit canonical), zeta (12-bit), out0, out1. It is instantiated 128 times.
- Operand and zeta selection is a per-stage generate plus a 7:1 mux indexed by `stage`.

## Test plan
- **Reset:** pulse `rst_n` low mid-cycle → `out`[*]=0, `valid`=0 and `busy`=0 immediately, before the next clock edge.
- **All ones:** `in`[k]=1 for all k, `enable` for one cycle → `valid` after 8 edges, `out`[0]=1, `out`[1]=1, all others 0.
- **Constant coefficient:** `in`[2k]=5, `in`[2k+1]=0 → `out`[0]=5, all others 0. Repeat with `in`[k]=3330 for all k → same result as the all-ones test (input reduction).
- **No scaling:** `SCALE_EN`=0 with all-ones input → `valid` after 7 edges, `out`[0]=`out`[1]=128, all others 0.
- **Round trip and back-to-back:**
  - Stimulus: 20 random polynomials through golden forward NTT → `intt`.
  - Required: output equals the original polynomial.
  - With `enable` held high, captures are spaced exactly 9 edges apart.
  - Toggling `enable` while `busy` does not change the result.
- **Reset mid-transform:** assert `rst_n`=0 at stage 3 → no `valid`, `out` all 0. The next `enable` produces the correct all-ones result.
